// File: rtl/contador_ascendente_n.sv
// -----------------------------------------------------------------------------
// contador_ascendente_n
//
// Programmable up-counting timer. A start request captures the terminal value
// from `limite` and counts 0,1,...,limite_q, one step per clock. On reaching
// the terminal count it emits a one-cycle `fin` pulse and either stops (DONE)
// or, with `auto_recarga`, wraps to 0 and keeps running while a saturating
// wrap counter records how many times that happened.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   limite       terminal count value, captured only when start is accepted
//   start        start / restart request (accepted in any state)
//   pause        level; holds the count while high (only acts in RUN)
//   clear        synchronous return to IDLE
//   auto_recarga 1 = wrap to 0 at terminal count and continue, 0 = stop
//   contador     current count
//   activo       high in RUN or PAUSE
//   fin          one-cycle pulse when the terminal count is reached
//   vueltas      number of auto-reload wraps, saturating at all-ones
//   estado       IDLE=00, RUN=01, PAUSE=10, DONE=11
//
// Control priority at each edge: rst > clear > start > pause > counting.
// -----------------------------------------------------------------------------
module contador_ascendente_n #(
  parameter int N         = 4,
  parameter int W_VUELTAS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         limite,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 clear,
  input  logic                 auto_recarga,
  output logic [N-1:0]         contador,
  output logic                 activo,
  output logic                 fin,
  output logic [W_VUELTAS-1:0] vueltas,
  output logic [1:0]           estado
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic [1:0]   state;
  logic [N-1:0] limite_q;

  // The state encoding is the external estado code, so both outputs are a
  // direct read / trivial decode of the state register.
  assign estado = state;
  assign activo = (state == RUN) || (state == PAUSE);

  // NOTE: all state lives in one clocked block using non-blocking assignments;
  // the unconditional `fin <= 1'b0` first gives the pulse its default and any
  // later assignment in the same edge overrides it.
  always_ff @(posedge clk) begin
    fin <= 1'b0;
    if (rst) begin
      state    <= IDLE;
      contador <= '0;
      vueltas  <= '0;
      limite_q <= '0;
    end else if (clear) begin
      state    <= IDLE;
      contador <= '0;
      vueltas  <= '0;
    end else if (start) begin
      limite_q <= limite;
      contador <= '0;
      vueltas  <= '0;
      if (limite == '0) begin
        // Zero-length run: terminal count is reached immediately.
        state <= DONE;
        fin   <= 1'b1;
      end else begin
        state <= RUN;
      end
    end else begin
      case (state)
        IDLE: begin
          contador <= '0;
        end

        RUN: begin
          if (pause) begin
            state <= PAUSE;
          end else if (contador == limite_q) begin
            fin <= 1'b1;
            // auto_recarga only matters on this edge.
            if (auto_recarga) begin
              contador <= '0;
              if (vueltas != '1) begin
                vueltas <= vueltas + 1'b1;
              end
            end else begin
              state <= DONE;
            end
          end else begin
            // contador < limite_q here, so the increment cannot overflow N bits.
            contador <= contador + 1'b1;
          end
        end

        PAUSE: begin
          // Leaving PAUSE costs one edge; counting resumes on the next one.
          if (!pause) begin
            state <= RUN;
          end
        end

        default: begin
          // DONE: hold limite_q on contador until start/clear/rst.
          contador <= limite_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_ascendente_n.sv
// -----------------------------------------------------------------------------
// tb_contador_ascendente_n
//
// Scoreboard bench: every driven cycle runs a behavioural model of the timer,
// pushes the predicted outputs into a queue, and after the clock edge the
// oldest prediction is popped and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_contador_ascendente_n;

  localparam int N  = 4;
  localparam int WV = 8;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  typedef struct packed {
    logic [N-1:0]  cnt;
    logic          act;
    logic          fin;
    logic [WV-1:0] vue;
    logic [1:0]    st;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, pause, clear, auto_recarga;
  logic [N-1:0]  limite;
  logic [N-1:0]  contador;
  logic          activo, fin;
  logic [WV-1:0] vueltas;
  logic [1:0]    estado;

  contador_ascendente_n #(.N(N), .W_VUELTAS(WV)) dut (
    .clk          (clk),
    .rst          (rst),
    .limite       (limite),
    .start        (start),
    .pause        (pause),
    .clear        (clear),
    .auto_recarga (auto_recarga),
    .contador     (contador),
    .activo       (activo),
    .fin          (fin),
    .vueltas      (vueltas),
    .estado       (estado)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t sb_q[$];

  // Model state.
  logic [1:0]    m_st;
  logic [N-1:0]  m_cnt, m_lim;
  logic [WV-1:0] m_vue;
  logic          m_fin;

  // Observations gathered across a scenario.
  int fin_seen;
  int max_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference behaviour of one clock edge.
  task automatic model_edge(input logic r, input logic cl, input logic st,
                            input logic pa, input logic ar, input logic [N-1:0] lim);
    m_fin = 1'b0;
    if (r) begin
      m_st = S_IDLE; m_cnt = '0; m_vue = '0; m_lim = '0;
    end else if (cl) begin
      m_st = S_IDLE; m_cnt = '0; m_vue = '0;
    end else if (st) begin
      m_lim = lim; m_cnt = '0; m_vue = '0;
      if (lim == 0) begin
        m_st = S_DONE; m_fin = 1'b1;
      end else begin
        m_st = S_RUN;
      end
    end else if (m_st == S_RUN) begin
      if (pa) begin
        m_st = S_PAUSE;
      end else if (m_cnt == m_lim) begin
        m_fin = 1'b1;
        if (ar) begin
          m_cnt = '0;
          if (m_vue < 8'd255) m_vue = m_vue + 8'd1;
        end else begin
          m_st = S_DONE;
        end
      end else begin
        m_cnt = m_cnt + 4'd1;
      end
    end else if (m_st == S_PAUSE) begin
      if (!pa) m_st = S_RUN;
    end
    // IDLE holds 0 and DONE holds the limit; nothing changes there.
  endtask

  // Drive one cycle of stimulus, predict, clock, then compare.
  task automatic tick(input logic r, input logic cl, input logic st,
                      input logic pa, input logic ar, input logic [N-1:0] lim);
    exp_t e, got_e;
    rst = r; clear = cl; start = st; pause = pa; auto_recarga = ar; limite = lim;
    model_edge(r, cl, st, pa, ar, lim);
    e.cnt = m_cnt;
    e.act = (m_st == S_RUN) || (m_st == S_PAUSE);
    e.fin = m_fin;
    e.vue = m_vue;
    e.st  = m_st;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got_e = sb_q.pop_front();
      check("contador", 32'(contador), 32'(got_e.cnt));
      check("activo",   32'(activo),   32'(got_e.act));
      check("fin",      32'(fin),      32'(got_e.fin));
      check("vueltas",  32'(vueltas),  32'(got_e.vue));
      check("estado",   32'(estado),   32'(got_e.st));
    end
    if (fin === 1'b1) fin_seen++;
    if (int'(contador) > max_cnt) max_cnt = int'(contador);
  endtask

  // Shorthand for a plain counting cycle with no control asserted.
  task automatic idle_ticks(input int n, input logic ar, input logic [N-1:0] lim);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, ar, lim);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; pause = 1'b0;
    auto_recarga = 1'b0; limite = '0;
    m_st = S_IDLE; m_cnt = '0; m_lim = '0; m_vue = '0; m_fin = 1'b0;
    fin_seen = 0; max_cnt = 0;

    // Reset state.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    idle_ticks(2, 1'b0, 4'd0);

    // limite=3, stop at terminal count, then hold in DONE for 10+ cycles.
    fin_seen = 0;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    idle_ticks(14, 1'b0, 4'd3);
    check("single_fin_count", 32'(fin_seen), 32'd1);
    check("done_estado", 32'(estado), 32'(S_DONE));
    check("done_hold", 32'(contador), 32'd3);

    // Pause in DONE is ignored.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);

    // limite=3 with auto-reload, 10 edges from the start edge.
    fin_seen = 0;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
    idle_ticks(9, 1'b1, 4'd3);
    check("reload_fin_count", 32'(fin_seen), 32'd2);
    check("reload_vueltas", 32'(vueltas), 32'd2);
    check("reload_cnt_e9", 32'(contador), 32'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);

    // Pause in IDLE is ignored.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);

    // limite=5 with a 3-cycle pause at contador=2; limite input wanders.
    fin_seen = 0;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
    idle_ticks(2, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    check("pause_hold_cnt", 32'(contador), 32'd2);
    check("pause_estado", 32'(estado), 32'(S_PAUSE));
    idle_ticks(10, 1'b0, 4'd0);
    check("pause_fin_count", 32'(fin_seen), 32'd1);
    check("pause_final_cnt", 32'(contador), 32'd5);

    // limite=0: immediate DONE with fin.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check("zero_fin", 32'(fin), 32'd1);
    idle_ticks(3, 1'b0, 4'd0);

    // rst mid-count: no fin afterwards.
    fin_seen = 0;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
    idle_ticks(2, 1'b1, 4'd5);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    idle_ticks(8, 1'b1, 4'd5);
    check("rst_no_fin", 32'(fin_seen), 32'd0);

    // clear and start together -> IDLE.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    idle_ticks(2, 1'b0, 4'd6);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6);
    check("clear_wins", 32'(estado), 32'(S_IDLE));
    idle_ticks(2, 1'b0, 4'd6);

    // start and pause together in RUN -> restart into RUN.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    idle_ticks(2, 1'b0, 4'd4);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    check("start_over_pause", 32'(estado), 32'(S_RUN));
    idle_ticks(7, 1'b0, 4'd4);

    // auto_recarga toggled mid-count: only its value at terminal edges matters.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
    for (int i = 0; i < 40; i++)
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // limite=15 (all-ones) with auto-reload for 300 wraps: saturation, no overflow.
    max_cnt = 0;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
    idle_ticks(300 * 16, 1'b1, 4'd15);
    check("vueltas_sat", 32'(vueltas), 32'd255);
    check("max_cnt", 32'(max_cnt), 32'd15);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
    check("restart_vueltas", 32'(vueltas), 32'd0);
    idle_ticks(3, 1'b1, 4'd15);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
